// File: rtl/pm_best_state_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pm_best_state_merge_pkg
// Description : Shared definitions for the best-state sequencing/merge stage
//               and the 32-way path-metric minimum tree: widths, FSM state
//               encodings, candidate struct and the modular-compare rule.
// Revision    : 1.0 - initial release
// ============================================================================
package pm_best_state_merge_pkg;

    // Slice select width (must track the tree's slice select)
    localparam int GLB_U   = 1;
    // State-metric width
    localparam int SM_W    = 8;
    // Trellis state index width (64 states)
    localparam int IDX_W   = 6;

    // Sequencer FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SL0   = 2'd1;
    localparam logic [1:0] ST_SL1   = 2'd2;
    localparam logic [1:0] ST_MERGE = 2'd3;

    // One (state index, metric) candidate
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [SM_W-1:0]  val;
    } pm_cand_t;

    // Modular minimum: returns 1 when x1 is the smaller metric in the
    // wrap-around sense. Path metrics are allowed to overflow, so the MSBs
    // flip the sense of the low-bit compare. Equal metrics return 0, so
    // the second operand wins ties. The tree uses the same function.
    function automatic logic pm_sel_x1(input logic [SM_W-1:0] x1,
                                       input logic [SM_W-1:0] x2);
        return x1[SM_W-1] ^ x2[SM_W-1] ^ (x1[SM_W-2:0] < x2[SM_W-2:0]);
    endfunction

endpackage : pm_best_state_merge_pkg
`default_nettype wire

// File: rtl/pm_best_state_merge_if.sv
`default_nettype none
// ============================================================================
// Module      : pm_best_state_merge_if
// Description : Bundle between the best-state merge stage, the minimum tree
//               and the downstream consumers (traceback start, PM normaliser).
//               slave  : the merge stage itself
//               master : the environment (controller + tree + consumers)
// Ports       : start_in, tree_idx_in, tree_val_in          (into merge)
//               slice_out, en_comp_out, busy_out,
//               best_valid_out, best_idx_out, best_val_out,
//               norm_req_out, norm_offset_out, step_cnt_out  (out of merge)
// Revision    : 1.0 - initial release
// ============================================================================
interface pm_best_state_merge_if
    import pm_best_state_merge_pkg::*;
#(
    parameter int U     = GLB_U,
    parameter int CNT_W = 10
);
    logic                 start_in;
    logic [U-1:0]         slice_out;
    logic                 en_comp_out;
    logic [IDX_W-1:0]     tree_idx_in;
    logic [SM_W-1:0]      tree_val_in;
    logic                 busy_out;
    logic                 best_valid_out;
    logic [IDX_W-1:0]     best_idx_out;
    logic [SM_W-1:0]      best_val_out;
    logic                 norm_req_out;
    logic [SM_W-1:0]      norm_offset_out;
    logic [CNT_W-1:0]     step_cnt_out;

    modport slave (
        input  start_in,
        input  tree_idx_in,
        input  tree_val_in,
        output slice_out,
        output en_comp_out,
        output busy_out,
        output best_valid_out,
        output best_idx_out,
        output best_val_out,
        output norm_req_out,
        output norm_offset_out,
        output step_cnt_out
    );

    modport master (
        output start_in,
        output tree_idx_in,
        output tree_val_in,
        input  slice_out,
        input  en_comp_out,
        input  busy_out,
        input  best_valid_out,
        input  best_idx_out,
        input  best_val_out,
        input  norm_req_out,
        input  norm_offset_out,
        input  step_cnt_out
    );

endinterface : pm_best_state_merge_if
`default_nettype wire

// File: rtl/pm_mod_compare.sv
`default_nettype none
// ============================================================================
// Module      : pm_mod_compare
// Description : Combinational two-input modular-minimum selector. Picks the
//               (metric, index) pair with the smaller wrap-around metric;
//               ties select the second operand.
// Ports       : i_x1/i_idx1  first candidate
//               i_x2/i_idx2  second candidate
//               o_y/o_idx_y  winning candidate
// Revision    : 1.0 - initial release
// ============================================================================
module pm_mod_compare
    import pm_best_state_merge_pkg::*;
(
    input  wire logic [SM_W-1:0]  i_x1,
    input  wire logic [IDX_W-1:0] i_idx1,
    input  wire logic [SM_W-1:0]  i_x2,
    input  wire logic [IDX_W-1:0] i_idx2,
    output logic      [SM_W-1:0]  o_y,
    output logic      [IDX_W-1:0] o_idx_y
);

    logic w_sel_x1;

    assign w_sel_x1 = pm_sel_x1(i_x1, i_x2);
    assign o_y      = w_sel_x1 ? i_x1   : i_x2;
    assign o_idx_y  = w_sel_x1 ? i_idx1 : i_idx2;

endmodule : pm_mod_compare
`default_nettype wire

// File: rtl/pm_best_state_merge.sv
`default_nettype none
// ============================================================================
// Module      : pm_best_state_merge
// Description : Sequences the 32-way path-metric minimum tree over the two
//               32-state slices, registers each slice winner, merges them
//               with the modular-minimum rule and publishes the global best
//               state/metric, a normalisation request and a step counter.
// Ports       : clk, rst      clock, synchronous active-high reset
//               bus (slave)   start/tree inputs, slice/enable to the tree,
//                             busy, best result, normalisation, step count
// Parameters  : U        slice select width (matches the tree)
//               NORM_THR normalisation threshold on the best metric
//               CNT_W    trellis step counter width
// Revision    : 1.0 - initial release
// ============================================================================
module pm_best_state_merge
    import pm_best_state_merge_pkg::*;
#(
    parameter int              U        = GLB_U,
    parameter logic [SM_W-1:0] NORM_THR = 8'd128,
    parameter int              CNT_W    = 10
)(
    input  wire logic               clk,
    input  wire logic               rst,
    pm_best_state_merge_if.slave    bus
);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [U-1:0]      r_slice;
    logic              r_en_comp;
    logic              r_busy;

    pm_cand_t          r_cand0;
    pm_cand_t          r_cand1;

    logic              r_best_valid;
    logic [IDX_W-1:0]  r_best_idx;
    logic [SM_W-1:0]   r_best_val;
    logic              r_norm_req;
    logic [SM_W-1:0]   r_norm_offset;
    logic [CNT_W-1:0]  r_step_cnt;

    logic [SM_W-1:0]   w_win_val;
    logic [IDX_W-1:0]  w_win_idx;
    logic              w_norm_hit;

    // ------------------------------------------------------------------
    // Next-state logic. start_in is only looked at in IDLE, so a start
    // arriving while a search runs is simply dropped.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start_in) w_state_nxt = ST_SL0;
            ST_SL0:   w_state_nxt = ST_SL1;
            ST_SL1:   w_state_nxt = ST_MERGE;
            ST_MERGE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Slice merge: slice 0 winner is X1, slice 1 winner is X2, so a tie
    // resolves to the upper slice.
    // ------------------------------------------------------------------
    pm_mod_compare u_merge_cmp (
        .i_x1    (r_cand0.val),
        .i_idx1  (r_cand0.idx),
        .i_x2    (r_cand1.val),
        .i_idx2  (r_cand1.idx),
        .o_y     (w_win_val),
        .o_idx_y (w_win_idx)
    );

    assign w_norm_hit = (w_win_val >= NORM_THR);

    // ------------------------------------------------------------------
    // FSM and tree-control outputs. slice/en_comp/busy are decoded from
    // the next state so that they are registered and line up with the
    // state they describe (the tree is combinational, its result is
    // sampled in the same cycle the slice select is presented).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_slice   <= '0;
            r_en_comp <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_slice   <= (w_state_nxt == ST_SL1) ? U'(1) : '0;
            r_en_comp <= (w_state_nxt == ST_SL0) || (w_state_nxt == ST_SL1);
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Per-slice winner capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand0 <= '0;
            r_cand1 <= '0;
        end else begin
            if (r_state == ST_SL0) begin
                r_cand0.idx <= bus.tree_idx_in;
                r_cand0.val <= bus.tree_val_in;
            end
            if (r_state == ST_SL1) begin
                r_cand1.idx <= bus.tree_idx_in;
                r_cand1.val <= bus.tree_val_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result publication. best_* and norm_offset hold between pulses;
    // norm_offset only moves when a normalisation request is issued.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_best_valid  <= 1'b0;
            r_best_idx    <= '0;
            r_best_val    <= '0;
            r_norm_req    <= 1'b0;
            r_norm_offset <= '0;
            r_step_cnt    <= '0;
        end else if (r_state == ST_MERGE) begin
            r_best_valid <= 1'b1;
            r_best_idx   <= w_win_idx;
            r_best_val   <= w_win_val;
            r_norm_req   <= w_norm_hit;
            if (w_norm_hit) begin
                r_norm_offset <= w_win_val;
            end
            // Free-running wrap, no overflow indication
            r_step_cnt   <= r_step_cnt + CNT_W'(1);
        end else begin
            r_best_valid <= 1'b0;
            r_norm_req   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.slice_out       = r_slice;
    assign bus.en_comp_out     = r_en_comp;
    assign bus.busy_out        = r_busy;
    assign bus.best_valid_out  = r_best_valid;
    assign bus.best_idx_out    = r_best_idx;
    assign bus.best_val_out    = r_best_val;
    assign bus.norm_req_out    = r_norm_req;
    assign bus.norm_offset_out = r_norm_offset;
    assign bus.step_cnt_out    = r_step_cnt;

endmodule : pm_best_state_merge
`default_nettype wire

// File: tb/tb_pm_best_state_merge.sv
`default_nettype none
// ============================================================================
// Module      : tb_pm_best_state_merge
// Description : Self-checking bench for pm_best_state_merge. Two instances
//               run in lockstep (CNT_W=10 and CNT_W=2) behind a behavioural
//               tree model; results are compared against a wrap-around
//               minimum reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pm_best_state_merge;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pm_best_state_merge_if #(.U(1), .CNT_W(10)) bus_a ();
    pm_best_state_merge_if #(.U(1), .CNT_W(2))  bus_b ();

    pm_best_state_merge #(.U(1), .NORM_THR(8'd128), .CNT_W(10)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    pm_best_state_merge #(.U(1), .NORM_THR(8'd128), .CNT_W(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Tree model: best candidate of the currently selected slice
    logic [5:0] tbl_idx0, tbl_idx1;
    logic [7:0] tbl_val0, tbl_val1;
    logic       start;

    always_comb begin
        bus_a.start_in    = start;
        bus_b.start_in    = start;
        bus_a.tree_idx_in = bus_a.slice_out[0] ? tbl_idx1 : tbl_idx0;
        bus_a.tree_val_in = bus_a.slice_out[0] ? tbl_val1 : tbl_val0;
        bus_b.tree_idx_in = bus_b.slice_out[0] ? tbl_idx1 : tbl_idx0;
        bus_b.tree_val_in = bus_b.slice_out[0] ? tbl_val1 : tbl_val0;
    end

    // Reference model state
    int         exp_cnt;
    logic [5:0] exp_idx;
    logic [7:0] exp_val;
    logic [7:0] exp_off;
    logic       exp_norm;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First operand is the wrap-around minimum when the forward distance
    // from it to the second operand lies in 1..128 (half the metric circle).
    function automatic bit first_is_min(input int x1, input int x2);
        int d;
        d = (x2 - x1) & 255;
        return (d >= 1) && (d <= 128);
    endfunction

    task automatic model_reset();
        exp_cnt  = 0;
        exp_idx  = '0;
        exp_val  = '0;
        exp_off  = '0;
        exp_norm = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_slice"}, bus_a.slice_out,       0);
        chk({tag, "_en"},    bus_a.en_comp_out,     0);
        chk({tag, "_busy"},  bus_a.busy_out,        0);
        chk({tag, "_valid"}, bus_a.best_valid_out,  0);
        chk({tag, "_idx"},   bus_a.best_idx_out,    0);
        chk({tag, "_val"},   bus_a.best_val_out,    0);
        chk({tag, "_norm"},  bus_a.norm_req_out,    0);
        chk({tag, "_off"},   bus_a.norm_offset_out, 0);
        chk({tag, "_cnt"},   bus_a.step_cnt_out,    0);
        chk({tag, "_cntB"},  bus_b.step_cnt_out,    0);
    endtask

    // Idle cycles: nothing pulses and published results hold
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_busy",  bus_a.busy_out,        0);
            chk("idle_en",    bus_a.en_comp_out,     0);
            chk("idle_valid", bus_a.best_valid_out,  0);
            chk("idle_norm",  bus_a.norm_req_out,    0);
            chk("hold_idx",   bus_a.best_idx_out,    exp_idx);
            chk("hold_val",   bus_a.best_val_out,    exp_val);
            chk("hold_off",   bus_a.norm_offset_out, exp_off);
        end
    endtask

    // One search starting at the current negedge. With dup set, a second
    // start is presented during the SL1 cycle and must be ignored.
    task automatic do_search(input logic [5:0] i0, input logic [7:0] v0,
                             input logic [5:0] i1, input logic [7:0] v1,
                             input bit dup);
        tbl_idx0 = i0; tbl_val0 = v0;
        tbl_idx1 = i1; tbl_val1 = v1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sl0_slice", bus_a.slice_out,      0);
        chk("sl0_en",    bus_a.en_comp_out,    1);
        chk("sl0_busy",  bus_a.busy_out,       1);
        chk("sl0_valid", bus_a.best_valid_out, 0);
        @(negedge clk);
        chk("sl1_slice", bus_a.slice_out,      1);
        chk("sl1_en",    bus_a.en_comp_out,    1);
        chk("sl1_busy",  bus_a.busy_out,       1);
        chk("sl1_valid", bus_a.best_valid_out, 0);
        if (dup) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mrg_en",    bus_a.en_comp_out,    0);
        chk("mrg_busy",  bus_a.busy_out,       1);
        chk("mrg_valid", bus_a.best_valid_out, 0);
        chk("mrg_cnt",   bus_a.step_cnt_out,   exp_cnt & 1023);
        @(negedge clk);
        if (first_is_min(v0, v1)) begin
            exp_idx = i0; exp_val = v0;
        end else begin
            exp_idx = i1; exp_val = v1;
        end
        exp_norm = (exp_val >= 8'd128);
        if (exp_norm) exp_off = exp_val;
        exp_cnt++;
        chk("res_valid", bus_a.best_valid_out,  1);
        chk("res_busy",  bus_a.busy_out,        0);
        chk("res_idx",   bus_a.best_idx_out,    exp_idx);
        chk("res_val",   bus_a.best_val_out,    exp_val);
        chk("res_norm",  bus_a.norm_req_out,    exp_norm);
        chk("res_off",   bus_a.norm_offset_out, exp_off);
        chk("res_cnt",   bus_a.step_cnt_out,    exp_cnt & 1023);
        chk("resB_valid", bus_b.best_valid_out, 1);
        chk("resB_idx",  bus_b.best_idx_out,    exp_idx);
        chk("resB_cnt",  bus_b.step_cnt_out,    exp_cnt & 3);
    endtask

    initial begin
        logic [5:0] ri0, ri1;
        logic [7:0] rv0, rv1;
        int         mode;

        rst      = 1'b1;
        start    = 1'b0;
        tbl_idx0 = '0; tbl_val0 = '0;
        tbl_idx1 = '0; tbl_val1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        idle_cycles(2);

        // Basic merge, modular wrap, tie to upper slice
        do_search(6'd5,  8'h10, 6'd40, 8'h20, 1'b0);
        idle_cycles(1);
        do_search(6'd3,  8'hF0, 6'd33, 8'h05, 1'b0);
        idle_cycles(1);
        do_search(6'd7,  8'h33, 6'd50, 8'h33, 1'b0);
        idle_cycles(2);

        // Busy/counter: ignored start in SL1, then accepted start at T+4
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_search(6'd1, 8'h40, 6'd60, 8'h41, 1'b1);
        do_search(6'd9, 8'h90, 6'd45, 8'h8F, 1'b0);
        idle_cycles(2);

        // Reset during SL1 discards the search
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all_zero("midrst");
        idle_cycles(4);

        // Reset wins over a simultaneous start
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_all_zero("rstwin");
        idle_cycles(4);
        do_search(6'd12, 8'h02, 6'd44, 8'h81, 1'b0);
        idle_cycles(1);

        // Randomized searches (also wraps the CNT_W=2 counter repeatedly)
        for (int n = 0; n < 60; n++) begin
            ri0  = 6'($urandom_range(0, 31));
            ri1  = 6'($urandom_range(32, 63));
            rv0  = 8'($urandom);
            mode = $urandom_range(0, 7);
            if (mode == 0)      rv1 = rv0;
            else if (mode == 1) rv1 = rv0 ^ 8'h80;
            else                rv1 = 8'($urandom);
            do_search(ri0, rv0, ri1, rv1, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pm_best_state_merge
`default_nettype wire
